irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_sync.sv | 32 +++
 rtl/irq_ctrl.sv | 148 ++++++++++++++
 tb/tb_irq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
// Provides the register offset map, the interrupt id width and a helper
// that builds the mask of implemented channel bits for a given channel count.
package irq_pkg;

    localparam int ID_W = 5;

    // Word offsets of the four registers relative to the block base address
    typedef enum logic [1:0] {
        OFF_PENDING = 2'd0,
        OFF_ENABLE  = 2'd1,
        OFF_MODE    = 2'd2,
        OFF_CLAIM   = 2'd3
    } reg_off_e;

    // One bit set for every implemented channel; the bits above stay zero
    function automatic logic [31:0] impl_mask(input int n);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-stage synchroniser for asynchronous request lines.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both stages
//   d_i    - asynchronous input lines
//   q_o    - synchronised lines (two clock edges of latency)
module irq_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two flop stages; the first may go metastable, the second is the clean copy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller.
// Registers (word addresses from BASE_ADDR): +0 PENDING (R, W1C), +1 ENABLE (R/W),
// +2 MODE (R/W, 1=edge 0=level), +3 CLAIM (R: [31]=interrupt, [4:0]=id).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   irq_in            - asynchronous request lines, one per channel
//   dbus_addr/write/wen - CPU data bus word address, write data, write enable
//   dbus_read         - read data, valid one cycle after the address
//   dbus_hit          - previous-cycle address fell in this block
//   interrupt         - registered OR of enabled pending channels
//   irq_id            - lowest-index enabled pending channel
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [15:0]      dbus_addr,
    input  logic [31:0]      dbus_write,
    input  logic             dbus_wen,
    output logic [31:0]      dbus_read,
    output logic             dbus_hit,
    output logic             interrupt,
    output logic [ID_W-1:0]  irq_id
);

    localparam logic [31:0] MASK = impl_mask(N_IRQ);

    // Register state is held 32 bits wide; bits at or above N_IRQ are forced to zero
    logic [N_IRQ-1:0] sync_s;
    logic [31:0]      sync_w_s;
    logic [31:0]      prev_q;
    logic [31:0]      rise_s;
    logic [31:0]      w1c_s;
    logic [31:0]      active_s;
    logic [31:0]      pend_q, pend_d;
    logic [31:0]      en_q, en_d;
    logic [31:0]      mode_q, mode_d;
    logic [31:0]      rd_q, rd_d;
    logic             hit_q;
    logic             int_q, int_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [15:0]      offset_s;
    logic             sel_s;
    reg_off_e         off_s;

    irq_sync #(
        .WIDTH (N_IRQ)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (irq_in),
        .q_o   (sync_s)
    );

    // Address decode; the subtraction wraps so addresses below the base miss
    always_comb begin
        offset_s = dbus_addr - BASE_ADDR;
        sel_s    = (offset_s < 16'd4);
        off_s    = reg_off_e'(offset_s[1:0]);
        sync_w_s = 32'd0;
        sync_w_s[N_IRQ-1:0] = sync_s;
    end

    // Register write decode and pending next-state
    always_comb begin
        w1c_s  = 32'd0;
        en_d   = en_q;
        mode_d = mode_q;
        if (dbus_wen && sel_s) begin
            case (off_s)
                OFF_PENDING: w1c_s  = dbus_write & MASK;
                OFF_ENABLE:  en_d   = dbus_write & MASK;
                OFF_MODE:    mode_d = dbus_write & MASK;
                OFF_CLAIM:   w1c_s  = 32'd0;
                default:     w1c_s  = 32'd0;
            endcase
        end else begin
            w1c_s = 32'd0;
        end
        rise_s = sync_w_s & ~prev_q;
        // Edge channels: a new rise wins over a simultaneous clear.
        // Level channels: mirror the synchronised line, ignoring clears.
        pend_d = ((mode_q & ((pend_q & ~w1c_s) | rise_s)) | (~mode_q & sync_w_s)) & MASK;
    end

    // Priority encode: scan downwards so the lowest active index is written last
    always_comb begin
        active_s = pend_q & en_q;
        int_d    = |active_s;
        id_d     = {ID_W{1'b0}};
        for (int i = 31; i >= 0; i--) begin
            if (active_s[i]) begin
                id_d = ID_W'(i);
            end else begin
                id_d = id_d;
            end
        end
    end

    // Read mux, registered so data arrives one cycle after the address
    always_comb begin
        rd_d = 32'd0;
        if (sel_s) begin
            case (off_s)
                OFF_PENDING: rd_d = pend_q;
                OFF_ENABLE:  rd_d = en_q;
                OFF_MODE:    rd_d = mode_q;
                OFF_CLAIM:   rd_d = {int_q, 26'd0, id_q};
                default:     rd_d = 32'd0;
            endcase
        end else begin
            rd_d = 32'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 32'd0;
            pend_q <= 32'd0;
            en_q   <= 32'd0;
            mode_q <= MASK;
            rd_q   <= 32'd0;
            hit_q  <= 1'b0;
            int_q  <= 1'b0;
            id_q   <= {ID_W{1'b0}};
        end else begin
            prev_q <= sync_w_s;
            pend_q <= pend_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            rd_q   <= rd_d;
            hit_q  <= sel_s;
            int_q  <= int_d;
            id_q   <= id_d;
        end
    end

    assign dbus_read = rd_q;
    assign dbus_hit  = hit_q;
    assign interrupt = int_q;
    assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table for the main register and
// interrupt sequences, then hand-written sequences for width masking and reset.
module tb_irq_ctrl;

    localparam logic [15:0] A_P = 16'hFF00;
    localparam logic [15:0] A_E = 16'hFF01;
    localparam logic [15:0] A_M = 16'hFF02;
    localparam logic [15:0] A_C = 16'hFF03;
    localparam logic [15:0] A_X = 16'h0000;

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [7:0]  irq;
        logic        hit;
        logic [31:0] rd;
        logic        intr;
        logic [4:0]  id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_in = 8'd0;
    logic [15:0] dbus_addr = 16'd0;
    logic [31:0] dbus_write = 32'd0;
    logic        dbus_wen = 1'b0;
    logic [31:0] rd8, rd4;
    logic        hit8, hit4, int8, int4;
    logic [4:0]  id8, id4;

    int n_chk = 0;
    int n_err = 0;
    vec_t vecs[$];

    irq_ctrl #(.N_IRQ(8), .BASE_ADDR(16'hFF00)) dut8 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .dbus_addr(dbus_addr),
        .dbus_write(dbus_write), .dbus_wen(dbus_wen), .dbus_read(rd8),
        .dbus_hit(hit8), .interrupt(int8), .irq_id(id8)
    );

    irq_ctrl #(.N_IRQ(4), .BASE_ADDR(16'hFF00)) dut4 (
        .clk(clk), .rst(rst), .irq_in(irq_in[3:0]), .dbus_addr(dbus_addr),
        .dbus_write(dbus_write), .dbus_wen(dbus_wen), .dbus_read(rd4),
        .dbus_hit(hit4), .interrupt(int4), .irq_id(id4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [7:0] q);
        @(negedge clk);
        dbus_wen   = w;
        dbus_addr  = a;
        dbus_write = d;
        irq_in     = q;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [31:0] d,
                                input logic [7:0] q, input logic h, input logic [31:0] r,
                                input logic it, input logic [4:0] id);
        vec_t v;
        v.wen = w; v.addr = a; v.wdata = d; v.irq = q;
        v.hit = h; v.rd = r; v.intr = it; v.id = id;
        return v;
    endfunction

    initial begin
        // Single pulse on channel 0 with only channel 0 enabled
        vecs.push_back(mk(1'b1, A_E, 32'h01, 8'h00, 1'b1, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_E, 32'h0,  8'h01, 1'b1, 32'h01, 1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_C, 32'h0,  8'h00, 1'b1, 32'h80000000, 1'b1, 5'd0));
        vecs.push_back(mk(1'b1, A_P, 32'h01, 8'h00, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h00, 1'b0, 32'h0,  1'b0, 5'd0));
        // Channels 5 and 2 together, then cleared one at a time
        vecs.push_back(mk(1'b1, A_E, 32'hFF, 8'h00, 1'b1, 32'h01, 1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h24, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h24, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h24, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h24, 1'b0, 32'h0,  1'b1, 5'd2));
        vecs.push_back(mk(1'b1, A_P, 32'h04, 8'h24, 1'b1, 32'h24, 1'b1, 5'd2));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h24, 1'b0, 32'h0,  1'b1, 5'd5));
        vecs.push_back(mk(1'b1, A_P, 32'h20, 8'h24, 1'b1, 32'h20, 1'b1, 5'd5));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h00, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h00, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h00, 1'b0, 32'h0,  1'b0, 5'd0));
        // Channel 0 in level mode: survives a clear while high, drops with the line
        vecs.push_back(mk(1'b1, A_M, 32'hFE, 8'h00, 1'b1, 32'hFF, 1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h01, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h01, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h01, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b1, A_P, 32'h01, 8'h01, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h01, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h01, 1'b1, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h00, 1'b0, 5'd0));
        vecs.push_back(mk(1'b1, A_M, 32'hFF, 8'h00, 1'b1, 32'hFE, 1'b0, 5'd0));
        // Edge on channel 3 landing on the same edge as its clear
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h08, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_X, 32'h0,  8'h08, 1'b0, 32'h0,  1'b0, 5'd0));
        vecs.push_back(mk(1'b1, A_P, 32'h08, 8'h08, 1'b1, 32'h00, 1'b0, 5'd0));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h08, 1'b1, 32'h08, 1'b1, 5'd3));
        vecs.push_back(mk(1'b1, A_P, 32'h08, 8'h08, 1'b1, 32'h08, 1'b1, 5'd3));
        vecs.push_back(mk(1'b0, A_P, 32'h0,  8'h00, 1'b1, 32'h00, 1'b0, 5'd0));
        // Address just past the register window
        vecs.push_back(mk(1'b0, 16'hFF04, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0, 5'd0));

        // Reset state, asynchronous with no clock edge yet
        #2;
        chk("reset_read8", rd8, 32'h0);
        chk("reset_hit8", {31'd0, hit8}, 32'h0);
        chk("reset_int8", {31'd0, int8}, 32'h0);
        chk("reset_id8", {27'd0, id8}, 32'h0);
        chk("reset_int4", {31'd0, int4}, 32'h0);
        chk("reset_id4", {27'd0, id4}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].irq);
            chk($sformatf("row%0d_hit", i), {31'd0, hit8}, {31'd0, vecs[i].hit});
            chk($sformatf("row%0d_read", i), rd8, vecs[i].rd);
            chk($sformatf("row%0d_int", i), {31'd0, int8}, {31'd0, vecs[i].intr});
            chk($sformatf("row%0d_id", i), {27'd0, id8}, {27'd0, vecs[i].id});
        end

        // Unimplemented bits of a 4-channel instance read back as zero
        apply(1'b1, A_E, 32'hFFFFFFFF, 8'h00);
        apply(1'b0, A_E, 32'h0, 8'h00);
        chk("n4_enable_read", rd4, 32'h0000000F);
        chk("n4_enable_hit", {31'd0, hit4}, 32'h1);
        chk("n8_enable_read", rd8, 32'h000000FF);

        // Build PENDING=0x0F with interrupt high, then reset in the middle of a write
        apply(1'b0, A_X, 32'h0, 8'h0F);
        apply(1'b0, A_X, 32'h0, 8'h0F);
        apply(1'b0, A_X, 32'h0, 8'h0F);
        apply(1'b0, A_P, 32'h0, 8'h0F);
        chk("pre_rst_pending", rd8, 32'h0F);
        chk("pre_rst_int", {31'd0, int8}, 32'h1);
        @(negedge clk);
        dbus_wen   = 1'b1;
        dbus_addr  = A_E;
        dbus_write = 32'hFF;
        irq_in     = 8'h02;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_int", {31'd0, int8}, 32'h0);
        chk("rst_async_read", rd8, 32'h0);
        chk("rst_async_hit", {31'd0, hit8}, 32'h0);
        chk("rst_async_id", {27'd0, id8}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        dbus_wen  = 1'b0;
        dbus_addr = A_M;
        @(posedge clk);
        #1;
        chk("rst_mode8", rd8, 32'hFF);
        chk("rst_mode4", rd4, 32'h0F);
        // Write during reset discarded; a line high at release still registers as an edge
        apply(1'b0, A_E, 32'h0, 8'h02);
        chk("rst_enable_discarded", rd8, 32'h0);
        apply(1'b0, A_P, 32'h0, 8'h02);
        chk("release_pending_early", rd8, 32'h0);
        apply(1'b0, A_P, 32'h0, 8'h02);
        chk("release_pending_set", rd8, 32'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
